// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC and issues one instruction-memory request at a time.
// Returned instructions go to decode through an output register backed by a one-entry skid buffer.
module fetch_stage #(
    parameter int                  ARCH_LEN = 32,
    parameter int                  INST_LEN = 32,
    parameter logic [ARCH_LEN-1:0] RESET_PC = 32'h0000_1000,
    parameter logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_fetch,
    input  logic                redirect_valid,
    input  logic [ARCH_LEN-1:0] redirect_pc,
    output logic                imem_req_valid,
    output logic [ARCH_LEN-1:0] imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    output logic [INST_LEN-1:0] inst_fetched_out,
    output logic                fetch_valid_out,
    output logic [ARCH_LEN-1:0] fetch_pc_out
);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [ARCH_LEN-1:0] PC_STEP = ARCH_LEN'(3'd4);

    function automatic logic [ARCH_LEN-1:0] word_align(input logic [ARCH_LEN-1:0] addr);
        return addr & ~ARCH_LEN'(2'b11);
    endfunction

    fetch_state_t        state_r;
    logic [ARCH_LEN-1:0] pc_r;
    logic [ARCH_LEN-1:0] req_pc_r;
    logic                drop_r;

    logic                out_valid_r;
    logic [INST_LEN-1:0] out_inst_r;
    logic [ARCH_LEN-1:0] out_pc_r;
    logic                skid_valid_r;
    logic [INST_LEN-1:0] skid_inst_r;
    logic [ARCH_LEN-1:0] skid_pc_r;

    logic                consume_s;
    logic                handshake_s;
    logic                resp_new_s;

    // A request is only offered while the skid buffer has room for its answer.
    assign imem_req_valid = (state_r == S_REQ) & ~skid_valid_r & ~rst;
    assign imem_req_addr  = pc_r;

    // Per-cycle events; a redirect kills any response landing in the same cycle.
    always_comb begin
        consume_s   = out_valid_r & ~stall_fetch;
        handshake_s = imem_req_valid & imem_req_ready;
        resp_new_s  = (state_r == S_WAIT) & imem_resp_valid & ~drop_r & ~redirect_valid;
    end

    // Request FSM: PC, in-flight request PC and the drop flag for flushed fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_REQ;
            pc_r     <= RESET_PC;
            req_pc_r <= RESET_PC;
            drop_r   <= 1'b0;
        end else if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
            if ((state_r == S_WAIT) && imem_resp_valid) begin
                drop_r  <= 1'b0;
                state_r <= S_REQ;
            end else if ((state_r == S_WAIT) || handshake_s) begin
                drop_r  <= 1'b1;
                state_r <= S_WAIT;
            end else begin
                drop_r  <= 1'b0;
                state_r <= S_REQ;
            end
        end else begin
            case (state_r)
                S_REQ: begin
                    if (handshake_s) begin
                        req_pc_r <= pc_r;
                        pc_r     <= pc_r + PC_STEP;
                        state_r  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        drop_r  <= 1'b0;
                        state_r <= S_REQ;
                    end
                end
                default: begin
                    drop_r  <= 1'b0;
                    state_r <= S_REQ;
                end
            endcase
        end
    end

    // Output register and skid buffer; skid always drains ahead of a new response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_inst_r   <= NOP_INST;
            out_pc_r     <= RESET_PC;
            skid_valid_r <= 1'b0;
            skid_inst_r  <= NOP_INST;
            skid_pc_r    <= RESET_PC;
        end else if (redirect_valid) begin
            out_valid_r  <= 1'b0;
            out_inst_r   <= NOP_INST;
            skid_valid_r <= 1'b0;
        end else if (consume_s) begin
            if (skid_valid_r) begin
                out_valid_r  <= 1'b1;
                out_inst_r   <= skid_inst_r;
                out_pc_r     <= skid_pc_r;
                skid_valid_r <= resp_new_s;
                if (resp_new_s) begin
                    skid_inst_r <= imem_resp_data;
                    skid_pc_r   <= req_pc_r;
                end
            end else if (resp_new_s) begin
                out_valid_r <= 1'b1;
                out_inst_r  <= imem_resp_data;
                out_pc_r    <= req_pc_r;
            end else begin
                out_valid_r <= 1'b0;
                out_inst_r  <= NOP_INST;
            end
        end else if (resp_new_s) begin
            if (out_valid_r) begin
                skid_valid_r <= 1'b1;
                skid_inst_r  <= imem_resp_data;
                skid_pc_r    <= req_pc_r;
            end else begin
                out_valid_r <= 1'b1;
                out_inst_r  <= imem_resp_data;
                out_pc_r    <= req_pc_r;
            end
        end
    end

    assign inst_fetched_out = out_inst_r;
    assign fetch_valid_out  = out_valid_r;
    assign fetch_pc_out     = out_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked against
// a program-order stream model (sequential PCs, restarted at each redirect target).
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst_fetched_out;
    logic        fetch_valid_out;
    logic [31:0] fetch_pc_out;

    int total = 0;
    int bad   = 0;

    bit          mem_auto = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_fetch      (stall_fetch),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_data   (imem_resp_data),
        .inst_fetched_out (inst_fetched_out),
        .fetch_valid_out  (fetch_valid_out),
        .fetch_pc_out     (fetch_pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5AC3, a[31:16] ^ 16'h0F0F};
    endfunction

    // One clock; when enabled, the memory model answers each accepted request after 1..3 cycles.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_resp_valid = 1'b0;
            if (hs) begin
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = a;
            end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(mem_addr);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_fetch = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        mem_auto = 1'b0; mem_cnt = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_fetch = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        tick();
        total++; if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fetch_valid_out); end
        total++; if (inst_fetched_out !== NOP) begin bad++; $display("FAIL reset_inst: got %h want %h", inst_fetched_out, NOP); end
        total++; if (fetch_pc_out !== 32'h1000) begin bad++; $display("FAIL reset_pc: got %h want 00001000", fetch_pc_out); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        rst = 1'b0;
        #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin bad++; $display("FAIL reset_first_req: got %b/%h want 1/00001000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_basic();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_wait: got req_valid %b want 0", imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h0050_0093 || fetch_pc_out !== 32'h1000) begin bad++; $display("FAIL basic_out: got %b/%h/%h want 1/00500093/00001000", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1004) begin bad++; $display("FAIL basic_next_req: got %b/%h want 1/00001004", imem_req_valid, imem_req_addr); end
        tick();
        total++; if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP) begin bad++; $display("FAIL basic_consumed: got %b/%h want 0/%h", fetch_valid_out, inst_fetched_out, NOP); end
    endtask

    task automatic test_stall_skid();
        do_reset();
        imem_req_ready = 1'b1; stall_fetch = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h11;
        tick();
        imem_resp_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h22;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h11 || fetch_pc_out !== 32'h1000) begin bad++; $display("FAIL stall_hold: got %b/%h/%h want 1/00000011/00001000", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_no_req: got %b want 0", imem_req_valid); end
            tick();
        end
        stall_fetch = 1'b0;
        tick();
        total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h22 || fetch_pc_out !== 32'h1004) begin bad++; $display("FAIL skid_drain: got %b/%h/%h want 1/00000022/00001004", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1008) begin bad++; $display("FAIL skid_next_req: got %b/%h want 1/00001008", imem_req_valid, imem_req_addr); end
        tick();
        total++; if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL skid_empty: got %b want 0", fetch_valid_out); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h2002;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        total++; if (fetch_valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_wait: got valid %b req %b want 0/0", fetch_valid_out, imem_req_valid); end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL redir_dropped: got valid %b inst %h want 0", fetch_valid_out, inst_fetched_out); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin bad++; $display("FAIL redir_req: got %b/%h want 1/00002000", imem_req_valid, imem_req_addr); end
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h33;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h33 || fetch_pc_out !== 32'h2000) begin bad++; $display("FAIL redir_target_out: got %b/%h/%h want 1/00000033/00002000", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        imem_req_ready = 1'b1; stall_fetch = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h44;
        tick();
        imem_resp_valid = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h55;
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        tick();
        imem_resp_valid = 1'b0; redirect_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP) begin bad++; $display("FAIL redresp_flush: got %b/%h want 0/%h", fetch_valid_out, inst_fetched_out, NOP); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin bad++; $display("FAIL redresp_req: got %b/%h want 1/00003000", imem_req_valid, imem_req_addr); end
        stall_fetch = 1'b0;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h66;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h66 || fetch_pc_out !== 32'h3000) begin bad++; $display("FAIL redresp_out: got %b/%h/%h want 1/00000066/00003000", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
    endtask

    task automatic test_not_ready();
        do_reset();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin bad++; $display("FAIL nr_req: got %b/%h want 1/00001000", imem_req_valid, imem_req_addr); end
            total++; if (fetch_valid_out !== 1'b0 || inst_fetched_out !== NOP) begin bad++; $display("FAIL nr_out: got %b/%h want 0/%h", fetch_valid_out, inst_fetched_out, NOP); end
        end
    endtask

    task automatic test_reset_wait_wrap();
        do_reset();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0BAD;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL stale_ignored: got valid %b inst %h want 0", fetch_valid_out, inst_fetched_out); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin bad++; $display("FAIL stale_req: got %b/%h want 1/00001000", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h77;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_valid_out !== 1'b1 || inst_fetched_out !== 32'h77 || fetch_pc_out !== 32'h1000) begin bad++; $display("FAIL restart_out: got %b/%h/%h want 1/00000077/00001000", fetch_valid_out, inst_fetched_out, fetch_pc_out); end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req: got %h want fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h88;
        tick();
        imem_resp_valid = 1'b0;
        total++; if (fetch_pc_out !== 32'hFFFF_FFFC || inst_fetched_out !== 32'h88) begin bad++; $display("FAIL wrap_out: got %h/%h want fffffffc/00000088", fetch_pc_out, inst_fetched_out); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_next: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        logic        redir;
        do_reset();
        mem_auto = 1'b1;
        exp_pc   = 32'h1000;
        consumed = 0;
        for (int i = 0; i < 2000; i++) begin
            stall_fetch    = ($urandom_range(0, 3) == 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            redir          = ($urandom_range(0, 24) == 0) || (i == 1000);
            redirect_valid = redir;
            redirect_pc    = (i == 1000) ? 32'hFFFF_FFF6 : $urandom;
            if (!fetch_valid_out) begin
                total++; if (inst_fetched_out !== NOP) begin bad++; $display("FAIL rnd_nop: got %h want %h", inst_fetched_out, NOP); end
            end
            if (redir) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (fetch_valid_out && !stall_fetch) begin
                total++;
                if (fetch_pc_out !== exp_pc || inst_fetched_out !== mem_word(exp_pc)) begin
                    bad++; $display("FAIL rnd_stream: got %h/%h want %h/%h", fetch_pc_out, inst_fetched_out, exp_pc, mem_word(exp_pc));
                end
                exp_pc   = exp_pc + 32'd4;
                consumed++;
            end
            tick();
            if (redir) begin
                total++; if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL rnd_flush: got valid %b want 0", fetch_valid_out); end
            end
        end
        redirect_valid = 1'b0;
        mem_auto       = 1'b0;
        total++; if (consumed < 100) begin bad++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_resp();
        test_not_ready();
        test_reset_wait_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
